pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 192, payload width in bits (decode-to-execute bundle).
REQ-002 Parameter CNT_W, default 16, statistics counter width in bits.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 flush  in  1  synchronous kill of all held entries (branch mispredict, jump redirect).
REQ-006 in_valid  in  1  upstream holds a valid payload.
REQ-007 in_ready  out  1  stage accepts a payload this cycle.
REQ-008 in_data  in  DATA_W  upstream payload.
REQ-009 out_valid  out  1  out_data is valid.
REQ-010 out_ready  in  1  downstream consumes out_data this cycle.
REQ-011 out_data  out  DATA_W  payload to the next stage.
REQ-012 occupancy  out  2  number of held entries: 0, 1 or 2.

Function
REQ-013 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-014 The stage holds two entries, main and skid; out_data/out_valid come from main only.
REQ-015 States: EMPTY (none held), BUSY (main only), FULL (main and skid).
REQ-016 in_ready = (state != FULL), driven from a register, with no combinational path from out_ready.
REQ-017 EMPTY: in_fire -> BUSY, main <= in_data.
REQ-018 BUSY: in_fire & out_fire -> BUSY, main <= in_data; in_fire & !out_fire -> FULL, skid <= in_data; !in_fire & out_fire -> EMPTY; otherwise hold.
REQ-019 FULL: out_fire -> BUSY, main <= skid; otherwise hold.
REQ-020 Latency is one cycle from in_fire to out_valid; sustained throughput is one payload per cycle while out_ready=1.
REQ-021 Delivery is strict FIFO; a payload is never duplicated or dropped, except by flush.
REQ-022 out_data and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 flush has priority over every transition: next state is EMPTY, main and skid payloads are cleared to 0, and the same-cycle in_data is discarded.
REQ-024 When out_valid=0, out_data SHALL be all-zero, so a bubble is the zero payload (NOP, no register/memory write).
REQ-025 occupancy reports 0, 1 or 2 for EMPTY, BUSY or FULL respectively.

Reset
REQ-026 While rst=1: state=EMPTY, main=0, skid=0, out_valid=0, out_data=0, occupancy=0, in_ready=0.
REQ-027 in_ready rises on the first clock edge after rst deasserts.
REQ-028 rst asserted mid-transfer discards all held entries, with no partial output.

Configuration
REQ-029 Macro PIPE_SKID_STATS_EN: when defined, adds outputs stall_cnt[CNT_W] and flush_cnt[CNT_W].
REQ-030 stall_cnt increments each cycle with out_valid & !out_ready.
REQ-031 flush_cnt increments each flush cycle with occupancy != 0 or in_fire.
REQ-032 Both counters saturate at all-ones and are cleared by rst only.
REQ-033 Without PIPE_SKID_STATS_EN, these ports and their logic are absent and all other behaviour is identical.

Structure
REQ-034 Shared package pipe_pkg holds the state encoding (EMPTY=2'b00, BUSY=2'b01, FULL=2'b10) and the defaults for DATA_W and CNT_W.
REQ-035 Sub-module pipe_sat_counter (CNT_W-bit, inc enable, saturating) is instantiated twice under PIPE_SKID_STATS_EN.

Verification
REQ-036 Streaming: out_ready=1, in_valid=1 with data 1..8 -> out_data 1..8 on consecutive cycles, each one cycle after its accept.
REQ-037 Backpressure: send A, B with out_ready=0 -> occupancy=2, in_ready=0, out_data=A stable; raise out_ready -> A then B delivered, occupancy 2->1->0.
REQ-038 Flush while FULL with in_valid=1 (data C) -> next cycle occupancy=0, out_valid=0, out_data=0, and C is never delivered.
REQ-039 Reset mid-stream: assert rst while BUSY -> outputs zero immediately (asynchronous); after release, in_ready=1 after one edge.
REQ-040 Stats (PIPE_SKID_STATS_EN, CNT_W=4): hold out_ready=0 for 20 valid cycles -> stall_cnt=15 (saturated); 3 flushes with entries held -> flush_cnt=3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the decode-to-execute skid stage: state encoding
// and default widths.
package pipe_pkg;

  localparam int unsigned DEF_DATA_W = 192;
  localparam int unsigned DEF_CNT_W  = 16;

  // Encoding equals the held-entry count, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the optional stall/flush statistics.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = pipe_pkg::DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry (main + skid) pipeline register with registered in_ready and flush.
// Define PIPE_SKID_STATS_EN to add saturating stall_cnt / flush_cnt outputs.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  if (DATA_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipe_skid_stage: DATA_W and CNT_W must be at least 1");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;

  // Payload registers are zeroed whenever they drain so a bubble reads as NOP.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = BUSY;
            main_d  = in_data;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = '0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = BUSY;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

`ifdef PIPE_SKID_STATS_EN
  logic stall_inc, flush_inc;

  assign stall_inc = out_valid & ~out_ready;
  assign flush_inc = flush & ((state_q != EMPTY) | in_fire);

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed self-checking bench for pipe_skid_stage (stats checks when
// PIPE_SKID_STATS_EN is defined).
module tb_pipe_skid_stage;

  localparam int DW = 192;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
`ifdef PIPE_SKID_STATS_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  localparam logic [DW-1:0] PA = {64'hAAAA_0000_1111_2222, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5};
  localparam logic [DW-1:0] PB = {64'hBBBB_3333_4444_5555, 64'h1, 64'h5A5A_5A5A_5A5A_5A5A};
  localparam logic [DW-1:0] PC = {64'hCCCC_6666_7777_8888, 64'h2, 64'hFFFF_0000_FFFF_0000};

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_occ", DW'(occupancy), '0);
    chk("rst_in_ready", DW'(in_ready), '0);
    step();
    @(negedge clk);
    rst = 1'b0;
    chk("in_ready_before_edge", DW'(in_ready), '0);
    step();
    chk("in_ready_after_edge", DW'(in_ready), DW'(1));

    // streaming 1..8, each visible one cycle after accept
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = DW'(i);
      chk($sformatf("stream_ready_%0d", i), DW'(in_ready), DW'(1));
      step();
      chk($sformatf("stream_data_%0d", i), out_data, DW'(i));
      chk($sformatf("stream_valid_%0d", i), DW'(out_valid), DW'(1));
    end
    in_valid = 1'b0;
    in_data  = '0;
    step();
    chk("stream_drain_valid", DW'(out_valid), '0);
    chk("stream_drain_data", out_data, '0);
    chk("stream_drain_occ", DW'(occupancy), '0);

    // backpressure: A, B held, then drained in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = PA;
    step();
    chk("bp_occ1", DW'(occupancy), DW'(1));
    in_data = PB;
    step();
    chk("bp_occ2", DW'(occupancy), DW'(2));
    chk("bp_in_ready", DW'(in_ready), '0);
    chk("bp_data_a", out_data, PA);
    in_valid = 1'b0;
    in_data  = '0;
    step();
    chk("bp_stable_data", out_data, PA);
    chk("bp_stable_valid", DW'(out_valid), DW'(1));
    chk("bp_stable_occ", DW'(occupancy), DW'(2));
    out_ready = 1'b1;
    step();
    chk("bp_deliver_b", out_data, PB);
    chk("bp_occ_after1", DW'(occupancy), DW'(1));
    chk("bp_in_ready_back", DW'(in_ready), DW'(1));
    step();
    chk("bp_occ_after2", DW'(occupancy), '0);
    chk("bp_empty_data", out_data, '0);

    // flush while FULL with C offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = PA;
    step();
    in_data = PB;
    step();
    chk("fl_pre_occ", DW'(occupancy), DW'(2));
    flush   = 1'b1;
    in_data = PC;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    chk("fl_occ", DW'(occupancy), '0);
    chk("fl_valid", DW'(out_valid), '0);
    chk("fl_data", out_data, '0);
    out_ready = 1'b1;
    step();
    step();
    chk("fl_no_c_valid", DW'(out_valid), '0);
    chk("fl_no_c_data", out_data, '0);

    // flush while BUSY with in_ready=1: same-cycle payload discarded
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = PA;
    step();
    flush   = 1'b1;
    in_data = PC;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flb_occ", DW'(occupancy), '0);
    chk("flb_data", out_data, '0);

    // asynchronous reset while BUSY
    in_valid = 1'b1;
    in_data  = PB;
    step();
    in_valid = 1'b0;
    chk("ar_pre_data", out_data, PB);
    rst = 1'b1;
    #1;
    chk("ar_valid", DW'(out_valid), '0);
    chk("ar_data", out_data, '0);
    chk("ar_occ", DW'(occupancy), '0);
    chk("ar_in_ready", DW'(in_ready), '0);
    step();
    @(negedge clk);
    rst = 1'b0;
    chk("ar_in_ready_held", DW'(in_ready), '0);
    step();
    chk("ar_in_ready_up", DW'(in_ready), DW'(1));
    chk("ar_after_valid", DW'(out_valid), '0);

`ifdef PIPE_SKID_STATS_EN
    do_reset();
    chk("st_stall_rst", DW'(stall_cnt), '0);
    chk("st_flush_rst", DW'(flush_cnt), '0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = PA;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("st_stall_sat", DW'(stall_cnt), DW'(15));
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        in_valid = 1'b1;
        in_data  = PB;
        step();
        in_valid = 1'b0;
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
    end
    step();
    chk("st_flush_cnt", DW'(flush_cnt), DW'(3));
    chk("st_stall_hold", DW'(stall_cnt), DW'(15));
`else
    do_reset();
    chk("final_occ", DW'(occupancy), '0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
